// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI device arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    localparam int DEV_COMP1 = 0;
    localparam int DEV_COMP2 = 1;
    localparam int DEV_RELAY = 2;
    localparam int NUM_DEV   = 3;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant: combinational pick from ptr upward, registered pointer advance.
module rr_arbiter3
    import spi_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_DEV-1:0] req_i,
    input  logic               take_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [2:0] cand;

    // Offsets are visited from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = ptr_q;
        cand    = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'(NUM_DEV)) begin
                cand = cand - 3'(NUM_DEV);
            end
            if (req_i[cand[1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take_i && valid_o) begin
            ptr_d = (idx_o == 2'(NUM_DEV - 1)) ? 2'd0 : idx_o + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_dev_arbiter.sv
// Mode-0 SPI master time-sharing sclk/mosi between comp1, comp2 and relay, granted round-robin.
// Define SPI_ARB_READBACK_EN to add miso capture with rdata/rvalid.
module spi_dev_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned SPI_DIV    = 2,
    parameter int unsigned WORD_BITS  = 16,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 clk_12mhz,
    input  logic                 rst,
    input  logic [2:0]           req,
    input  logic [WORD_BITS-1:0] wdata0,
    input  logic [WORD_BITS-1:0] wdata1,
    input  logic [WORD_BITS-1:0] wdata2,
`ifdef SPI_ARB_READBACK_EN
    input  logic                 miso,
    output logic [WORD_BITS-1:0] rdata,
    output logic                 rvalid,
`endif
    output logic [2:0]           ack,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 comp1_cs,
    output logic                 comp2_cs,
    output logic                 relay_cs
);

    localparam int unsigned HALF_W = $clog2(2 * WORD_BITS);
    localparam logic [7:0] DIV_LAST = 8'(SPI_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_BITS - 1);

    state_e               state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [1:0]           grant_q, grant_d;
    logic [2:0]           cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic [2:0]           ack_q, ack_d;

    logic                 arb_valid;
    logic [1:0]           arb_idx;
    logic                 arb_take;
    logic [WORD_BITS-1:0] word_sel;

    assign arb_take = (state_q == IDLE);

    rr_arbiter3 u_arb (
        .clk_i   (clk_12mhz),
        .rst_i   (rst),
        .req_i   (req),
        .take_i  (arb_take),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_comb begin
        case (arb_idx)
            2'(DEV_COMP1): word_sel = wdata0;
            2'(DEV_COMP2): word_sel = wdata1;
            default:       word_sel = wdata2;
        endcase
    end

    // NOTE: every next-state signal is defaulted to its register first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        shift_d = shift_q;
        grant_d = grant_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d          = arb_idx;
                    shift_d          = word_sel;
                    mosi_d           = word_sel[WORD_BITS-1];
                    cs_n_d           = '1;
                    cs_n_d[arb_idx]  = 1'b0;
                    div_d            = '0;
                    state_d          = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = HOLD;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        // Even index is a high half-period, so the next boundary is a falling edge.
                        if (!half_q[0]) begin
                            sclk_d  = 1'b0;
                            shift_d = shift_q << 1;
                            mosi_d  = shift_d[WORD_BITS-1];
                        end else begin
                            sclk_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d          = '0;
                    cs_n_d         = '1;
                    ack_d[grant_q] = 1'b1;
                    mosi_d         = 1'b0;
                    shift_d        = '0;
                    state_d        = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            shift_q <= '0;
            grant_q <= '0;
            cs_n_q  <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            shift_q <= shift_d;
            grant_q <= grant_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SPI_ARB_READBACK_EN
    logic [WORD_BITS-1:0] rx_q, rx_shift, rdata_q;
    logic                 rvalid_q;

    always_comb begin
        rx_shift    = rx_q << 1;
        rx_shift[0] = miso;
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            rx_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= |ack_d;
            if (sclk_d && !sclk_q) begin
                rx_q <= rx_shift;
            end
            if (|ack_d) begin
                rdata_q <= rx_q;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign ack      = ack_q;
    assign busy     = (state_q != IDLE);
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign comp1_cs = cs_n_q[DEV_COMP1];
    assign comp2_cs = cs_n_q[DEV_COMP2];
    assign relay_cs = cs_n_q[DEV_RELAY];

    a_one_cs_low: assert property (@(posedge clk_12mhz) disable iff (rst) $onehot0(~cs_n_q));

endmodule

// File: tb/tb_spi_dev_arbiter.sv
// Randomized self-checking bench for spi_dev_arbiter; default and a DIV=1/8-bit instance.
module tb_spi_dev_arbiter;

    localparam int DIV   = 2;
    localparam int WB    = 16;
    localparam int GAP   = 4;
    localparam int S_DIV = 1;
    localparam int S_WB  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      req, s_req;
    logic [WB-1:0]   wdata0, wdata1, wdata2;
    logic [S_WB-1:0] s_wdata0, s_wdata1, s_wdata2;
    logic [2:0]      ack, s_ack;
    logic            busy, sclk, mosi, comp1_cs, comp2_cs, relay_cs;
    logic            s_busy, s_sclk, s_mosi, s_comp1_cs, s_comp2_cs, s_relay_cs;
`ifdef SPI_ARB_READBACK_EN
    logic            miso, s_miso, rvalid, s_rvalid;
    logic [WB-1:0]   rdata;
    logic [S_WB-1:0] s_rdata;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int model_ptr = 0;

    spi_dev_arbiter #(.SPI_DIV(DIV), .WORD_BITS(WB), .GAP_CYCLES(GAP)) dut (
        .clk_12mhz(clk), .rst(rst), .req(req),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
`ifdef SPI_ARB_READBACK_EN
        .miso(miso), .rdata(rdata), .rvalid(rvalid),
`endif
        .ack(ack), .busy(busy), .sclk(sclk), .mosi(mosi),
        .comp1_cs(comp1_cs), .comp2_cs(comp2_cs), .relay_cs(relay_cs)
    );

    spi_dev_arbiter #(.SPI_DIV(S_DIV), .WORD_BITS(S_WB), .GAP_CYCLES(GAP)) dut_s (
        .clk_12mhz(clk), .rst(rst), .req(s_req),
        .wdata0(s_wdata0), .wdata1(s_wdata1), .wdata2(s_wdata2),
`ifdef SPI_ARB_READBACK_EN
        .miso(s_miso), .rdata(s_rdata), .rvalid(s_rvalid),
`endif
        .ack(s_ack), .busy(s_busy), .sclk(s_sclk), .mosi(s_mosi),
        .comp1_cs(s_comp1_cs), .comp2_cs(s_comp2_cs), .relay_cs(s_relay_cs)
    );

    // Capture task observes whichever instance mon_sel points at.
    logic       mon_sel;
    logic [2:0] mon_cs, mon_ack;
    logic       mon_sclk, mon_mosi, mon_busy;
    assign mon_cs   = mon_sel ? {s_relay_cs, s_comp2_cs, s_comp1_cs} : {relay_cs, comp2_cs, comp1_cs};
    assign mon_ack  = mon_sel ? s_ack  : ack;
    assign mon_sclk = mon_sel ? s_sclk : sclk;
    assign mon_mosi = mon_sel ? s_mosi : mosi;
    assign mon_busy = mon_sel ? s_busy : busy;

    // Reference arbitration rule: first set request at or after ptr, wrapping.
    function automatic int pick(input logic [2:0] r, input int ptr);
        for (int off = 0; off < 3; off++) begin
            if (r[(ptr + off) % 3]) return (ptr + off) % 3;
        end
        return -1;
    endfunction

    // Chip-select exclusivity and inter-transaction gap on the default instance.
    int high_run = 0;
    bit seen_low = 0;
    always @(negedge clk) begin
        if (rst) begin
            high_run = 0;
            seen_low = 0;
        end else begin
            n_checks++;
            if (!$onehot0(~{relay_cs, comp2_cs, comp1_cs})) begin
                n_errors++;
                $display("FAIL cs_exclusive: cs=%b required at most one low", {relay_cs, comp2_cs, comp1_cs});
            end
            if ({relay_cs, comp2_cs, comp1_cs} == 3'b111) begin
                high_run++;
            end else begin
                if (seen_low && high_run > 0) begin
                    n_checks++;
                    if (high_run < GAP) begin
                        n_errors++;
                        $display("FAIL cs_gap: %0d idle cycles, required >= %0d", high_run, GAP);
                    end
                end
                seen_low = 1;
                high_run = 0;
            end
        end
    end

    task automatic capture(input string name, input int exp_dev, input logic [31:0] exp_word,
                           input int wb, input int div, input bit hold_req, input int pulse_k,
                           input logic [31:0] miso_word);
        int cs_cnt = 0, ack_cnt = 0, ack_k = -1, ack_dev = -1, end_k = -1, first_dev = -1;
        int nbits = 0, last_rise = -1, rise_err = 0, ovl = 0, rv_err = 0;
        int exp_cs, exp_end;
        logic [31:0] bits, mask;
        logic [2:0]  csv;
        logic        prev_sclk;
        bits      = '0;
        mask      = (wb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wb) - 32'd1);
        exp_cs    = 2 * div + 2 * wb * div;
        exp_end   = 1 + div + 2 * wb * div + div + GAP;
        prev_sclk = mon_sclk;
`ifdef SPI_ARB_READBACK_EN
        if (!mon_sel) miso = miso_word[wb-1];
`endif
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            csv = ~mon_cs;
            if (csv != 3'b000) begin
                cs_cnt++;
                if (first_dev < 0) first_dev = csv[0] ? 0 : (csv[1] ? 1 : 2);
            end
            if ($countones(csv) > 1) ovl++;
            if (mon_sclk && !prev_sclk) begin
                if (last_rise >= 0 && (k - last_rise) != 2 * div) rise_err++;
                last_rise = k;
                bits = {bits[30:0], mon_mosi};
                nbits++;
`ifdef SPI_ARB_READBACK_EN
                if (!mon_sel && nbits < wb) miso = miso_word[wb-1-nbits];
`endif
            end
            prev_sclk = mon_sclk;
`ifdef SPI_ARB_READBACK_EN
            if (!mon_sel) begin
                if (rvalid !== (ack != 3'b000)) rv_err++;
                if (ack != 3'b000 && rdata !== miso_word[WB-1:0]) rv_err++;
            end
`endif
            if (mon_ack != 3'b000) begin
                ack_cnt++;
                ack_k   = k;
                ack_dev = mon_ack[0] ? 0 : (mon_ack[1] ? 1 : 2);
                if (!hold_req) begin
                    if (mon_sel) s_req = '0;
                    else         req   = '0;
                end
            end
            if (k == pulse_k)     req[1] = 1'b1;
            if (k == pulse_k + 1) req[1] = 1'b0;
            if (!mon_busy) begin
                end_k = k;
                break;
            end
        end
        n_checks += 10;
        if (first_dev != exp_dev) begin n_errors++; $display("FAIL %s.grant: got dev %0d expected %0d", name, first_dev, exp_dev); end
        if (cs_cnt != exp_cs) begin n_errors++; $display("FAIL %s.cs_low: got %0d cycles expected %0d", name, cs_cnt, exp_cs); end
        if (nbits != wb) begin n_errors++; $display("FAIL %s.rises: got %0d expected %0d", name, nbits, wb); end
        if ((bits & mask) !== (exp_word & mask)) begin n_errors++; $display("FAIL %s.mosi: got %h expected %h", name, bits & mask, exp_word & mask); end
        if (ack_cnt != 1) begin n_errors++; $display("FAIL %s.ack_count: got %0d expected 1", name, ack_cnt); end
        if (ack_k != exp_cs + 1) begin n_errors++; $display("FAIL %s.ack_cycle: got %0d expected %0d", name, ack_k, exp_cs + 1); end
        if (ack_dev != exp_dev) begin n_errors++; $display("FAIL %s.ack_dev: got %0d expected %0d", name, ack_dev, exp_dev); end
        if (end_k != exp_end) begin n_errors++; $display("FAIL %s.length: got %0d expected %0d (-1 = timeout)", name, end_k, exp_end); end
        if (ovl != 0) begin n_errors++; $display("FAIL %s.overlap: got %0d cycles expected 0", name, ovl); end
        if (rise_err != 0) begin n_errors++; $display("FAIL %s.sclk_period: got %0d bad periods expected 0", name, rise_err); end
`ifdef SPI_ARB_READBACK_EN
        if (!mon_sel) begin
            n_checks++;
            if (rv_err != 0) begin n_errors++; $display("FAIL %s.readback: got %0d errors expected 0 (rdata=%h want %h)", name, rv_err, rdata, miso_word[WB-1:0]); end
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 6;
        if ({relay_cs, comp2_cs, comp1_cs} !== 3'b111) begin n_errors++; $display("FAIL reset.cs: got %b expected 111", {relay_cs, comp2_cs, comp1_cs}); end
        if (sclk !== 1'b0) begin n_errors++; $display("FAIL reset.sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0) begin n_errors++; $display("FAIL reset.mosi: got %b expected 0", mosi); end
        if (ack !== 3'b000) begin n_errors++; $display("FAIL reset.ack: got %b expected 000", ack); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset.busy: got %b expected 0", busy); end
        if ({s_relay_cs, s_comp2_cs, s_comp1_cs, s_sclk, s_busy} !== 5'b11100) begin
            n_errors++; $display("FAIL reset.sweep_dut: got %b expected 11100", {s_relay_cs, s_comp2_cs, s_comp1_cs, s_sclk, s_busy});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        int d;
        wdata0 = 16'($urandom);
        wdata1 = 16'($urandom);
        wdata2 = 16'($urandom);
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            d = pick(3'b111, model_ptr);
            model_ptr = (d + 1) % 3;
            case (d)
                0:       capture("contention", d, 32'(wdata0), WB, DIV, t < 3, -1, $urandom);
                1:       capture("contention", d, 32'(wdata1), WB, DIV, t < 3, -1, $urandom);
                default: capture("contention", d, 32'(wdata2), WB, DIV, t < 3, -1, $urandom);
            endcase
        end
    endtask

    task automatic test_single();
        wdata0 = 16'hA5C3;
        req = 3'b001;
        model_ptr = (pick(3'b001, model_ptr) + 1) % 3;
        capture("single", 0, 32'h0000_A5C3, WB, DIV, 1'b0, -1, $urandom);
    endtask

    task automatic test_cancel();
        int cs2_low = 0, ack1 = 0, busy_cnt = 0;
        wdata0 = 16'($urandom);
        wdata1 = 16'($urandom);
        req = 3'b001;
        model_ptr = (pick(3'b001, model_ptr) + 1) % 3;
        capture("cancel", 0, 32'(wdata0), WB, DIV, 1'b0, 10, $urandom);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!comp2_cs) cs2_low++;
            if (ack[1]) ack1++;
            if (busy) busy_cnt++;
        end
        n_checks += 3;
        if (cs2_low != 0) begin n_errors++; $display("FAIL cancel.comp2_cs: got %0d low cycles expected 0", cs2_low); end
        if (ack1 != 0) begin n_errors++; $display("FAIL cancel.ack1: got %0d pulses expected 0", ack1); end
        if (busy_cnt != 0) begin n_errors++; $display("FAIL cancel.busy: got %0d busy cycles expected 0", busy_cnt); end
    endtask

    task automatic test_random();
        logic [2:0] r;
        int d;
        for (int t = 0; t < 6; t++) begin
            r      = 3'($urandom_range(1, 7));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            wdata2 = 16'($urandom);
            d = pick(r, model_ptr);
            model_ptr = (d + 1) % 3;
            req = r;
            case (d)
                0:       capture("random", d, 32'(wdata0), WB, DIV, 1'b0, -1, $urandom);
                1:       capture("random", d, 32'(wdata1), WB, DIV, 1'b0, -1, $urandom);
                default: capture("random", d, 32'(wdata2), WB, DIV, 1'b0, -1, $urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_shift();
        int rises = 0, acks = 0;
        bit fired = 0;
        logic prev;
        wdata0 = 16'($urandom);
        req = 3'b001;
        prev = sclk;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
            if (ack != 3'b000) acks++;
            if (rises == 8) begin
                rst = 1'b1;
                #1;
                fired = 1;
                break;
            end
        end
        n_checks += 6;
        if (!fired) begin n_errors++; $display("FAIL rst_mid.reach: got %0d rises expected 8", rises); end
        if ({relay_cs, comp2_cs, comp1_cs} !== 3'b111) begin n_errors++; $display("FAIL rst_mid.cs: got %b expected 111", {relay_cs, comp2_cs, comp1_cs}); end
        if (sclk !== 1'b0) begin n_errors++; $display("FAIL rst_mid.sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0) begin n_errors++; $display("FAIL rst_mid.mosi: got %b expected 0", mosi); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid.busy: got %b expected 0", busy); end
        req = 3'b000;
        repeat (3) begin
            @(negedge clk);
            if (ack != 3'b000) acks++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack != 3'b000) acks++;
        end
        if (acks != 0) begin n_errors++; $display("FAIL rst_mid.ack: got %0d pulses expected 0", acks); end
        model_ptr = 0;
        wdata2 = 16'($urandom);
        req = 3'b100;
        model_ptr = (pick(3'b100, model_ptr) + 1) % 3;
        capture("after_reset", 2, 32'(wdata2), WB, DIV, 1'b0, -1, $urandom);
    endtask

    task automatic test_sweep();
        mon_sel  = 1'b1;
        s_wdata0 = 8'($urandom);
        s_wdata2 = 8'h81;
        s_req    = 3'b100;
        capture("sweep", 2, 32'h0000_0081, S_WB, S_DIV, 1'b0, -1, $urandom);
        s_wdata2 = 8'($urandom);
        s_req    = 3'b101;
        capture("sweep_rr", 0, 32'(s_wdata0), S_WB, S_DIV, 1'b0, -1, $urandom);
        mon_sel  = 1'b0;
    endtask

`ifdef SPI_ARB_READBACK_EN
    task automatic test_readback();
        int d;
        wdata1 = 16'($urandom);
        req = 3'b010;
        d = pick(3'b010, model_ptr);
        model_ptr = (d + 1) % 3;
        capture("readback", d, 32'(wdata1), WB, DIV, 1'b0, -1, 32'h0000_1234);
    endtask
`endif

    initial begin
        rst      = 1'b1;
        mon_sel  = 1'b0;
        req      = '0;
        s_req    = '0;
        wdata0   = '0;
        wdata1   = '0;
        wdata2   = '0;
        s_wdata0 = '0;
        s_wdata1 = '0;
        s_wdata2 = '0;
`ifdef SPI_ARB_READBACK_EN
        miso   = 1'b0;
        s_miso = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_contention();
        test_single();
        test_cancel();
        test_random();
        test_reset_mid_shift();
        test_sweep();
`ifdef SPI_ARB_READBACK_EN
        test_readback();
`endif
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
